fb_scanout_reader: RTL and testbench
====================================

// Module: fb_scanout_reader
// PURPOSE
//  AXI4 burst-read master that fetches one framebuffer frame from DDR and emits it as a pixel stream.
//  Sits downstream of the GPU framebuffer in DDR and upstream of the video output / scan timing logic.
//  Shares the DDR interconnect with the GPU's single-beat AXI master; this block owns the read path only.
//  Uses credit-based burst issue so the AXI R channel never stalls on a full internal FIFO.
// PARAMETERS
//  ADDR_WIDTH  32   AXI address width
//  DATA_WIDTH  32   AXI data width = one pixel per beat
//  ID_WIDTH    4    AXI ID width
//  BURST_LEN   16   beats per AR burst; power of 2, <=256
//  FIFO_DEPTH  64   pixel FIFO entries; power of 2, >= 2*BURST_LEN
//  FB_WIDTH    640  pixels per line
//  FB_HEIGHT   480  lines per frame
//  Constraint: FB_WIDTH*FB_HEIGHT is a multiple of BURST_LEN
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous active-low reset
//  i_start        in   1          start a frame fetch; sampled only in IDLE
//  i_fb_base      in   ADDR_WIDTH frame base byte address; low log2(BURST_LEN*4) bits forced to 0
//  o_busy         out  1          high from the accepted start until the last pixel handshake
//  o_frame_done   out  1          one-cycle pulse after the last pixel handshake
//  o_err          out  1          sticky error flag; cleared by an accepted start
//  m_axi_ar*      out  -          arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid
//  m_axi_arready  in   1          AR handshake
//  m_axi_r*       in   -          rid/rdata/rresp/rlast/rvalid
//  m_axi_rready   out  1          R handshake
//  o_pix_data     out  DATA_WIDTH pixel word
//  o_pix_valid    out  1          pixel valid (FIFO not empty)
//  i_pix_ready    in   1          consumer ready
//  o_pix_sof      out  1          qualifies the first pixel of the frame
//  o_pix_eol      out  1          qualifies the last pixel of each line (column == FB_WIDTH-1)
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. FIFO, counters and credits cleared.
//   Reset mid-frame abandons in-flight AXI bursts; the interconnect is reset together with this block.
//  Constant AR fields: arid=0, arlen=BURST_LEN-1, arsize=3'b010, arburst=INCR, arlock=0,
//   arcache=4'b0011, arprot=0, arqos=0.
//  FSM states:
//   IDLE:  i_start=1 -> latch base, clear o_err and counters -> RUN. arvalid may rise the next cycle.
//   RUN:   issue bursts k=0..NB-1, NB=FB_WIDTH*FB_HEIGHT/BURST_LEN; araddr=base+k*BURST_LEN*4.
//          Last AR handshake -> DRAIN.
//   DRAIN: wait for all R beats to arrive and all pixels to be consumed.
//          Last pixel handshake -> IDLE, with o_frame_done pulsed in the same cycle the FSM enters IDLE.
//  Credit rule: reserved = fifo_count + outstanding_beats.
//   arvalid may rise only when FIFO_DEPTH - reserved >= BURST_LEN.
//   An AR handshake adds BURST_LEN to outstanding_beats; each R beat moves one unit from outstanding to fifo_count.
//  AR handshake rule: once asserted, arvalid, araddr and all AR fields stay stable until arready.
//  m_axi_rready = (state != IDLE). The credit rule guarantees FIFO space for every beat.
//  R errors:
//   rresp != OKAY -> o_err=1; the beat is still pushed.
//   rlast mismatch (rlast asserted on a beat other than beat BURST_LEN-1, or missing on that beat) -> o_err=1.
//   The beat counter realigns on rlast.
//  FIFO: registered write with no bypass. The first R beat is visible on o_pix_valid one cycle after acceptance.
//   A simultaneous push and pop keeps fifo_count unchanged.
//  Pixel stream: data/valid/sof/eol are held stable while valid && !ready.
//   Column counter wraps at FB_WIDTH-1; pixel counter ends at FB_WIDTH*FB_HEIGHT-1.
//  i_start while busy is ignored: no latch, no o_err clear.
//  A new start is accepted in the cycle after o_frame_done.
//  Counters are sized with $clog2 of their maxima; address arithmetic wraps modulo 2^ADDR_WIDTH.
// TESTING (FB_WIDTH=32, FB_HEIGHT=4, BURST_LEN=16, FIFO_DEPTH=64 unless noted)
//  1. Start, base=0x1000_0000, ideal slave, ready=1
//     -> 8 ARs at 0x1000_0000 + k*0x40 with arlen=15; 128 pixels in order.
//     -> sof on pixel 0; eol on pixels 31/63/95/127; one o_frame_done pulse; o_busy falls.
//  2. i_pix_ready=0 throughout -> exactly 4 ARs issued, then arvalid stays 0.
//     Release ready for 16 pops -> 5th AR issued.
//  3. arready held 0 for 10 cycles -> arvalid and araddr unchanged across the stall; no AR is lost.
//  4. rresp=SLVERR on beat 5 of burst 2 -> o_err=1 and stays 1; all 128 pixels still delivered.
//     Next start clears o_err.
//  5. rlast asserted on beat 7 -> o_err=1.
//     Separately, i_start pulsed mid-frame -> ignored and addresses unchanged.
//  6. rst_n low mid-DRAIN -> all outputs 0 asynchronously.
//     After release, a new start fetches a full frame correctly.

Source files
------------

// File: rtl/fb_scanout_reader.sv
// AXI4 burst-read master that streams one framebuffer frame out of DDR as pixels.
// Bursts are issued only when the pixel FIFO has room for every beat, so R never backs up.
module fb_scanout_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_fb_base,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] o_pix_data,
    output logic                  o_pix_valid,
    input  logic                  i_pix_ready,
    output logic                  o_pix_sof,
    output logic                  o_pix_eol
);

    localparam int NUM_PIX    = FB_WIDTH * FB_HEIGHT;
    localparam int NUM_BURSTS = NUM_PIX / BURST_LEN;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_W    = $clog2(NUM_BURSTS + 1);
    localparam int COL_W      = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int PIX_W      = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int LOW_BITS   = $clog2(BURST_LEN * 4);

    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES  = ADDR_WIDTH'(BURST_LEN * 4);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK    = ~((ADDR_WIDTH'(1) << LOW_BITS) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0]      BURST_CREDIT = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic [BURST_W-1:0]     burst_cnt;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [COL_W-1:0]       col_cnt;
    logic [PIX_W-1:0]       pix_cnt;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       outstanding_next;
    logic [CNT_W:0]         reserved;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic                   push;
    logic                   pop;
    logic                   ar_hs;
    logic                   credit_ok;
    logic                   last_pix;
    logic                   unused_rid;

    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = '0;
    assign m_axi_arqos   = '0;
    assign unused_rid    = ^m_axi_rid;

    assign m_axi_rready = (state != IDLE);
    assign o_pix_valid  = (fifo_count != '0);
    assign o_pix_data   = o_pix_valid ? mem[rd_ptr] : '0;
    assign o_pix_sof    = o_pix_valid && (pix_cnt == '0);
    assign o_pix_eol    = o_pix_valid && (col_cnt == COL_W'(FB_WIDTH - 1));

    assign push      = m_axi_rvalid && m_axi_rready && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign pop       = o_pix_valid && i_pix_ready;
    assign ar_hs     = m_axi_arvalid && m_axi_arready;
    assign last_pix  = pop && (pix_cnt == PIX_W'(NUM_PIX - 1));
    assign reserved  = {1'b0, fifo_count} + {1'b0, outstanding};
    // Free space must cover a whole burst before its AR may go out.
    assign credit_ok = (reserved <= (CNT_W + 1)'(FIFO_DEPTH - BURST_LEN));

    always_comb begin
        outstanding_next = outstanding;
        if (ar_hs)
            outstanding_next = outstanding_next + BURST_CREDIT;
        if (push && outstanding_next != '0)
            outstanding_next = outstanding_next - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_err         <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            next_addr     <= '0;
            burst_cnt     <= '0;
            beat_cnt      <= '0;
            col_cnt       <= '0;
            pix_cnt       <= '0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= RUN;
                        o_busy    <= 1'b1;
                        o_err     <= 1'b0;
                        next_addr <= i_fb_base & BASE_MASK;
                        burst_cnt <= '0;
                        beat_cnt  <= '0;
                        col_cnt   <= '0;
                        pix_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        if (burst_cnt == BURST_W'(NUM_BURSTS))
                            state <= DRAIN;
                    end else if (!m_axi_arvalid && credit_ok &&
                                 burst_cnt != BURST_W'(NUM_BURSTS)) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= next_addr;
                        next_addr     <= next_addr + BURST_BYTES;
                        burst_cnt     <= burst_cnt + BURST_W'(1);
                    end
                end
                default: ;
            endcase

            if (state != IDLE) begin
                // Beat counter realigns on rlast so one bad burst does not poison the rest.
                if (push) begin
                    if (m_axi_rresp != 2'b00 ||
                        m_axi_rlast != (beat_cnt == BEAT_W'(BURST_LEN - 1)))
                        o_err <= 1'b1;
                    beat_cnt <= m_axi_rlast ? '0 : beat_cnt + BEAT_W'(1);
                end
                if (pop) begin
                    col_cnt <= (col_cnt == COL_W'(FB_WIDTH - 1)) ? '0 : col_cnt + COL_W'(1);
                    pix_cnt <= pix_cnt + PIX_W'(1);
                end
                if (last_pix) begin
                    state        <= IDLE;
                    o_busy       <= 1'b0;
                    o_frame_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count  <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= m_axi_rdata;
    end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader on a 32x4 frame with an in-bench AXI read slave.
// Slave returns rdata equal to the beat's byte address, so pixel i of a frame is base + 4*i.
module tb_fb_scanout_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_fb_base;
    logic        o_busy, o_frame_done, o_err;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] o_pix_data;
    logic        o_pix_valid;
    logic        i_pix_ready;
    logic        o_pix_sof;
    logic        o_pix_eol;

    int checks = 0;
    int failures = 0;

    logic [31:0] ar_log[$];
    logic [31:0] ar_pending[$];
    logic [31:0] pix_data_log[$];
    logic        sof_log[$];
    logic        eol_log[$];
    int          done_cnt = 0;
    int          arlen_bad = 0;
    int          r_beat = 0;
    int          r_burst_num = 0;
    int          inj_resp_burst = -1, inj_resp_beat = 0;
    int          inj_last_burst = -1, inj_last_beat = 0;
    int          ar_stall = 0;
    int          stall_obs = 0, stall_viol = 0;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    fb_scanout_reader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .BURST_LEN(16),
        .FIFO_DEPTH(64), .FB_WIDTH(32), .FB_HEIGHT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_fb_base(i_fb_base),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
        .o_pix_sof(o_pix_sof), .o_pix_eol(o_pix_eol)
    );

    // Slave and monitor: observe handshakes on the falling edge, drive new values 1 after the rising edge.
    initial begin
        logic obs_r_fire, obs_stalled;
        m_axi_arready = 1'b1;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        forever begin
            @(negedge clk);
            obs_r_fire  = m_axi_rvalid && m_axi_rready;
            obs_stalled = m_axi_arvalid && !m_axi_arready;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_log.push_back(m_axi_araddr);
                ar_pending.push_back(m_axi_araddr);
            end
            if (m_axi_arvalid && m_axi_arlen != 8'd15)
                arlen_bad++;
            if (o_pix_valid && i_pix_ready) begin
                pix_data_log.push_back(o_pix_data);
                sof_log.push_back(o_pix_sof);
                eol_log.push_back(o_pix_eol);
            end
            if (o_frame_done)
                done_cnt++;
            if (prev_stalled && (!m_axi_arvalid || m_axi_araddr !== prev_addr))
                stall_viol++;
            prev_stalled = obs_stalled;
            prev_addr    = m_axi_araddr;
            if (obs_stalled)
                stall_obs++;

            @(posedge clk);
            #1;
            if (!rst_n) begin
                ar_pending.delete();
                r_beat        = 0;
                ar_stall      = 0;
                m_axi_arready = 1'b1;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                m_axi_rresp   = 2'b00;
                m_axi_rdata   = '0;
            end else begin
                if (obs_r_fire) begin
                    if (r_beat == 15) begin
                        void'(ar_pending.pop_front());
                        r_beat = 0;
                        r_burst_num++;
                    end else begin
                        r_beat++;
                    end
                end
                if (obs_stalled && ar_stall > 0)
                    ar_stall--;
                m_axi_arready = (ar_stall == 0);
                if (ar_pending.size() > 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = ar_pending[0] + 32'(r_beat * 4);
                    m_axi_rlast  = (r_beat == 15) ||
                                   (r_burst_num == inj_last_burst && r_beat == inj_last_beat);
                    m_axi_rresp  = (r_burst_num == inj_resp_burst && r_beat == inj_resp_beat) ?
                                   2'b10 : 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base);
        ar_log.delete();
        pix_data_log.delete();
        sof_log.delete();
        eol_log.delete();
        done_cnt    = 0;
        r_burst_num = 0;
        i_fb_base   = base;
        i_start     = 1'b1;
        tick(1);
        i_start     = 1'b0;
    endtask

    task automatic waitFrame(input int max_cycles);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            tick(1);
            n++;
        end
    endtask

    task automatic checkFrame(input string tag, input logic [31:0] base);
        int bad_addr = 0, bad_data = 0, bad_sof = 0, bad_eol = 0;
        tick(4);
        checkOutput({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({tag, " busy_after"}, 32'(o_busy), 32'd0);
        checkOutput({tag, " ar_count"}, 32'(ar_log.size()), 32'd8);
        foreach (ar_log[k])
            if (ar_log[k] !== base + 32'(k * 64)) bad_addr++;
        checkOutput({tag, " ar_addr_errs"}, 32'(bad_addr), 32'd0);
        checkOutput({tag, " pix_count"}, 32'(pix_data_log.size()), 32'd128);
        foreach (pix_data_log[i]) begin
            if (pix_data_log[i] !== base + 32'(i * 4)) bad_data++;
            if (sof_log[i] !== ((i == 0) ? 1'b1 : 1'b0)) bad_sof++;
            if (eol_log[i] !== ((i % 32 == 31) ? 1'b1 : 1'b0)) bad_eol++;
        end
        checkOutput({tag, " pix_data_errs"}, 32'(bad_data), 32'd0);
        checkOutput({tag, " sof_errs"}, 32'(bad_sof), 32'd0);
        checkOutput({tag, " eol_errs"}, 32'(bad_eol), 32'd0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_fb_base   = '0;
        i_pix_ready = 1'b1;
        tick(3);

        $display("[TB] reset state");
        checkOutput("rst busy", 32'(o_busy), 32'd0);
        checkOutput("rst arvalid", 32'(m_axi_arvalid), 32'd0);
        checkOutput("rst rready", 32'(m_axi_rready), 32'd0);
        checkOutput("rst pix_valid", 32'(o_pix_valid), 32'd0);
        checkOutput("rst done_err", 32'({o_frame_done, o_err}), 32'd0);
        checkOutput("const arlen", 32'(m_axi_arlen), 32'd15);
        checkOutput("const arsize_burst", 32'({m_axi_arsize, m_axi_arburst}), 32'b010_01);
        checkOutput("const arcache", 32'(m_axi_arcache), 32'h3);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] t1 ideal frame");
        applyStimulus(32'h1000_0000);
        waitFrame(1000);
        checkFrame("t1", 32'h1000_0000);

        $display("[TB] t2 consumer backpressure and credits");
        i_pix_ready = 1'b0;
        applyStimulus(32'h1400_0000);
        tick(100);
        checkOutput("t2 ar_before_pops", 32'(ar_log.size()), 32'd4);
        checkOutput("t2 arvalid_held_low", 32'(m_axi_arvalid), 32'd0);
        checkOutput("t2 fifo_full_valid", 32'(o_pix_valid), 32'd1);
        i_pix_ready = 1'b1;
        tick(16);
        i_pix_ready = 1'b0;
        tick(1);
        checkOutput("t2 pops", 32'(pix_data_log.size()), 32'd16);
        tick(40);
        checkOutput("t2 ar_after_pops", 32'(ar_log.size()), 32'd5);
        i_pix_ready = 1'b1;
        waitFrame(1000);
        checkFrame("t2", 32'h1400_0000);

        $display("[TB] t3 arready stall");
        ar_stall   = 10;
        stall_obs  = 0;
        stall_viol = 0;
        tick(2);
        applyStimulus(32'h1800_0000);
        waitFrame(1000);
        checkOutput("t3 stall_cycles", 32'(stall_obs), 32'd10);
        checkOutput("t3 stall_changes", 32'(stall_viol), 32'd0);
        checkFrame("t3", 32'h1800_0000);

        $display("[TB] t4 slverr on burst 2 beat 5");
        inj_resp_burst = 2;
        inj_resp_beat  = 5;
        applyStimulus(32'h2000_0000);
        waitFrame(1000);
        checkFrame("t4", 32'h2000_0000);
        checkOutput("t4 err_set", 32'(o_err), 32'd1);
        inj_resp_burst = -1;
        tick(5);
        checkOutput("t4 err_sticky", 32'(o_err), 32'd1);

        $display("[TB] t4b restart clears error, unaligned base");
        applyStimulus(32'h2400_0025);
        tick(1);
        checkOutput("t4b err_cleared", 32'(o_err), 32'd0);
        waitFrame(1000);
        checkFrame("t4b", 32'h2400_0000);
        checkOutput("t4b err_clean", 32'(o_err), 32'd0);

        $display("[TB] t5 early rlast and ignored mid-frame start");
        inj_last_burst = 0;
        inj_last_beat  = 7;
        applyStimulus(32'h2800_0000);
        n = 0;
        while (o_err !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("t5 err_rlast", 32'(o_err), 32'd1);
        i_fb_base = 32'h3000_0000;
        i_start   = 1'b1;
        tick(1);
        i_start   = 1'b0;
        tick(2);
        checkOutput("t5 err_kept", 32'(o_err), 32'd1);
        checkOutput("t5 busy_kept", 32'(o_busy), 32'd1);
        waitFrame(1000);
        inj_last_burst = -1;
        checkFrame("t5", 32'h2800_0000);

        $display("[TB] t6 reset mid-drain");
        inj_resp_burst = 0;
        inj_resp_beat  = 0;
        applyStimulus(32'h3400_0000);
        n = 0;
        while (ar_log.size() < 8 && n < 500) begin
            tick(1);
            n++;
        end
        tick(2);
        checkOutput("t6 busy_pre", 32'(o_busy), 32'd1);
        checkOutput("t6 err_pre", 32'(o_err), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 ctl_async", 32'({o_busy, m_axi_arvalid, m_axi_rready, o_pix_valid,
                                          o_pix_sof, o_pix_eol, o_frame_done, o_err}), 32'd0);
        checkOutput("t6 pix_data_async", o_pix_data, 32'd0);
        checkOutput("t6 araddr_async", m_axi_araddr, 32'd0);
        tick(3);
        inj_resp_burst = -1;
        rst_n = 1'b1;
        tick(2);
        applyStimulus(32'h3800_0000);
        waitFrame(1000);
        checkFrame("t6", 32'h3800_0000);
        checkOutput("t6 err_after", 32'(o_err), 32'd0);

        checkOutput("arlen_while_valid", 32'(arlen_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
